// File: rtl/ir_pkg.sv
// Shared definitions for the instruction fetch register: fill-state enum,
// byte-counter width and the byte-to-lane mapping.
package ir_pkg;

    // FILL: bytes are being collected, IROut not valid. HOLD: IROut valid.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_e;

    localparam int unsigned NUM_BYTES_DEF = 2;
    localparam int unsigned IDX_W         = $clog2(NUM_BYTES_DEF);

    // Lane of the assembly register that receives byte number idx.
    function automatic int unsigned lane_of(input int unsigned idx,
                                            input int unsigned num_bytes,
                                            input bit          msb_first);
        return msb_first ? (num_bytes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/ir_byte_assembler.sv
// Byte counter, lane decode and assembly register. Produces the word with the
// current byte merged in and a strobe in the cycle the final byte is accepted.
module ir_byte_assembler
    import ir_pkg::*;
#(
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned NUM_BYTES = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         flush,
    input  logic                         accept,
    input  logic [BYTE_W-1:0]            data,
    output logic [$clog2(NUM_BYTES)-1:0] byte_idx,
    output logic [BYTE_W*NUM_BYTES-1:0]  word,
    output logic                         complete
);

    localparam int unsigned IW   = BYTE_W * NUM_BYTES;
    localparam int unsigned IdxW = $clog2(NUM_BYTES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

    logic [IdxW-1:0] idx_q, idx_d;
    logic [IW-1:0]   asm_q;

    // Merge the accepted byte into its lane; word equals asm_q when idle.
    always_comb begin
        word = asm_q;
        for (int unsigned l = 0; l < NUM_BYTES; l++) begin
            if (accept && (lane_of(32'(idx_q), NUM_BYTES, MSB_FIRST) == l)) begin
                word[l*BYTE_W +: BYTE_W] = data;
            end
        end
    end

    assign complete = accept && (idx_q == LastIdx);
    assign byte_idx = idx_q;

    // Next byte index: cleared by flush, advances and wraps on each accept.
    always_comb begin
        idx_d = idx_q;
        if (flush) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
    end

    // Counter and assembly register; lanes are never cleared between fills.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= word;
        end
    end

endmodule

// File: rtl/instruction_fetch_register.sv
// Instruction register assembled from a byte-serial memory stream, presented
// to the decoder with an IRValid/IRTake handshake.
// Optional feature: define IR_PREFETCH_EN to add a one-entry shadow register
// so the next instruction can fill while the current one waits to be taken.
module instruction_fetch_register
    import ir_pkg::*;
#(
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned NUM_BYTES = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic [BYTE_W-1:0]            I,
    input  logic                         Write,
    output logic                         Ready,
    input  logic                         Flush,
    output logic [BYTE_W*NUM_BYTES-1:0]  IROut,
    output logic                         IRValid,
    input  logic                         IRTake,
    output logic [$clog2(NUM_BYTES)-1:0] ByteIdx
);

    localparam int unsigned IW = BYTE_W * NUM_BYTES;

    fill_state_e   state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [IW-1:0] word;
    logic          accept;
    logic          complete;
    logic          take;

`ifdef IR_PREFETCH_EN
    logic [IW-1:0] shadow_q, shadow_d;
    logic          shadow_valid_q, shadow_valid_d;

    assign Ready = !shadow_valid_q;
`else
    assign Ready = (state_q == FILL);
`endif

    assign IRValid = (state_q == HOLD);
    assign IROut   = ir_q;
    assign take    = IRTake && IRValid;
    // Bytes offered during a flush are discarded.
    assign accept  = Write && Ready && !Flush;

    ir_byte_assembler #(
        .BYTE_W   (BYTE_W),
        .NUM_BYTES(NUM_BYTES),
        .MSB_FIRST(MSB_FIRST)
    ) u_assembler (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .flush   (Flush),
        .accept  (accept),
        .data    (I),
        .byte_idx(ByteIdx),
        .word    (word),
        .complete(complete)
    );

    // Fill FSM next state plus IROut / shadow loading.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
`ifdef IR_PREFETCH_EN
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
`endif
        if (Flush) begin
            state_d = FILL;
`ifdef IR_PREFETCH_EN
            shadow_valid_d = 1'b0;
`endif
        end else begin
`ifdef IR_PREFETCH_EN
            // Shadow is full only when Ready is low, so completion never
            // coincides with a shadow-to-IROut transfer.
            if (complete && (!IRValid || take)) begin
                ir_d    = word;
                state_d = HOLD;
            end else if (complete) begin
                shadow_d       = word;
                shadow_valid_d = 1'b1;
            end else if (take && shadow_valid_q) begin
                ir_d           = shadow_q;
                shadow_valid_d = 1'b0;
                state_d        = HOLD;
            end else if (take) begin
                state_d = FILL;
            end
`else
            case (state_q)
                FILL: begin
                    if (complete) begin
                        ir_d    = word;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (take) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
`endif
        end
    end

    // State registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= FILL;
            ir_q    <= '0;
`ifdef IR_PREFETCH_EN
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
`ifdef IR_PREFETCH_EN
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
`endif
        end
    end

endmodule
